// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for a Sync_FIFO: N_REQ producers share buf_in/wr_en.
// Issue is credit-paced from fifo_counter, and each owner may write at most BURST consecutive words.
module fifo_wr_arbiter #(
    parameter int N_REQ = 4,
    parameter int DW    = 8,
    parameter int DEPTH = 8,
    parameter int CW    = 4,
    parameter int BURST = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] req_data,
    input  logic [CW-1:0]       fifo_counter,
    output logic [N_REQ-1:0]    ack,
    output logic [DW-1:0]       buf_in,
    output logic                wr_en,
    output logic [N_REQ-1:0]    grant,
    output logic                busy
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int BW = $clog2(BURST + 1);

    typedef enum logic {ST_IDLE, ST_BURST} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic            wr_en_q, wr_en_d;
    logic [DW-1:0]   buf_in_q, buf_in_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic            busy_q, busy_d;

    logic [CW:0]     occ;
    logic            ok;
    logic [PW-1:0]   start;
    logic [PW-1:0]   cand;
    logic [PW-1:0]   win;
    logic            win_found;

    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] x);
        if (int'(x) == N_REQ - 1) return '0;
        return x + PW'(1);
    endfunction

    // The write already in flight has not yet shown up in fifo_counter.
    assign occ = {1'b0, fifo_counter} + {{CW{1'b0}}, wr_en_q};
    assign ok  = occ < (CW+1)'(DEPTH);

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        beat_d    = beat_q;
        wr_en_d   = 1'b0;
        buf_in_d  = buf_in_q;
        ack       = '0;
        start     = ptr_q;
        cand      = '0;
        win       = '0;
        win_found = 1'b0;

        if (state_q == ST_BURST && req[owner_q] && beat_q < BW'(BURST)) begin
            // Owner keeps the port; without credit it simply stalls.
            if (ok) begin
                ack[owner_q] = 1'b1;
                wr_en_d      = 1'b1;
                buf_in_d     = req_data[owner_q*DW +: DW];
                beat_d       = beat_q + BW'(1);
            end
        end else begin
            if (state_q == ST_BURST) begin
                start = next_idx(owner_q);
                ptr_d = start;
            end
            for (int k = 0; k < N_REQ; k++) begin
                cand = PW'((int'(start) + k) % N_REQ);
                if (!win_found && req[cand]) begin
                    win_found = 1'b1;
                    win       = cand;
                end
            end
            if (win_found && ok) begin
                ack[win] = 1'b1;
                wr_en_d  = 1'b1;
                buf_in_d = req_data[win*DW +: DW];
                state_d  = ST_BURST;
                owner_d  = win;
                beat_d   = BW'(1);
            end else begin
                state_d = ST_IDLE;
                beat_d  = '0;
            end
        end

        grant_d = (state_d == ST_BURST) ? (N_REQ'(1) << owner_d) : '0;
        busy_d  = (state_d == ST_BURST);

        if (!rst) ack = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            ptr_q    <= '0;
            beat_q   <= '0;
            wr_en_q  <= 1'b0;
            buf_in_q <= '0;
            grant_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            beat_q   <= beat_d;
            wr_en_q  <= wr_en_d;
            buf_in_q <= buf_in_d;
            grant_q  <= grant_d;
            busy_q   <= busy_d;
        end
    end

    assign wr_en  = wr_en_q;
    assign buf_in = buf_in_q;
    assign grant  = grant_q;
    assign busy   = busy_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: inputs change after the falling edge, outputs are sampled 1ns later.
module tb_fifo_wr_arbiter;
    localparam int N_REQ = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int CW    = 4;
    localparam int BURST = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  fifo_counter;
    logic [3:0]  ack;
    logic [7:0]  buf_in;
    logic        wr_en;
    logic [3:0]  grant;
    logic        busy;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cnt[4];
    logic [31:0] dv;
    logic [7:0]  exp_prev;

    fifo_wr_arbiter #(
        .N_REQ(N_REQ), .DW(DW), .DEPTH(DEPTH), .CW(CW), .BURST(BURST)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .fifo_counter(fifo_counter), .ack(ack), .buf_in(buf_in),
        .wr_en(wr_en), .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] q, input logic [31:0] d, input logic [3:0] fc);
        @(negedge clk);
        rst = r; req = q; req_data = d; fifo_counter = fc;
        #1;
    endtask

    initial begin
        rst = 1'b0; req = 4'hF; req_data = 32'h0; fifo_counter = 4'd0;

        // Reset with every producer requesting
        for (int c = 0; c < 2; c++) begin
            drive(1'b0, 4'hF, 32'h4433_2211, 4'd0);
            chk("rst_ack", ack, 0);
            chk("rst_wr_en", wr_en, 0);
            chk("rst_buf_in", buf_in, 0);
            chk("rst_grant", grant, 0);
            chk("rst_busy", busy, 0);
        end
        drive(1'b1, 4'h0, 32'h0, 4'd0);
        chk("idle_ack", ack, 0);

        // Producer 1 alone, two words back to back
        drive(1'b1, 4'b0010, 32'h0000_1100, 4'd0);
        chk("p1_ack0", ack, 4'b0010);
        drive(1'b1, 4'b0010, 32'h0000_2200, 4'd0);
        chk("p1_ack1", ack, 4'b0010);
        chk("p1_wr0", wr_en, 1);
        chk("p1_buf0", buf_in, 8'h11);
        chk("p1_grant", grant, 4'b0010);
        drive(1'b1, 4'b0000, 32'h0, 4'd0);
        chk("p1_ack2", ack, 0);
        chk("p1_wr1", wr_en, 1);
        chk("p1_buf1", buf_in, 8'h22);
        drive(1'b1, 4'b0000, 32'h0, 4'd0);
        chk("p1_wr_off", wr_en, 0);
        chk("p1_buf_hold", buf_in, 8'h22);
        chk("p1_grant_off", grant, 0);
        chk("p1_busy_off", busy, 0);

        // All four continuously, FIFO drained: p0x4, p1x4, p2x4, p3x4, p0x4
        drive(1'b0, 4'h0, 32'h0, 4'd0);
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        exp_prev = 8'h00;
        for (int c = 0; c < 20; c++) begin
            for (int i = 0; i < 4; i++) dv[i*8 +: 8] = {4'(i), 4'(cnt[i])};
            drive(1'b1, 4'hF, dv, 4'd0);
            chk("rr_ack", ack, 32'(1) << ((c / 4) % 4));
            if (c > 0) begin
                chk("rr_wr_en", wr_en, 1);
                chk("rr_buf_in", buf_in, exp_prev);
                chk("rr_grant", grant, 32'(1) << (((c - 1) / 4) % 4));
            end
            exp_prev = {4'((c / 4) % 4), 4'((c / 16) * 4 + c % 4)};
            for (int i = 0; i < 4; i++) if (ack[i]) cnt[i]++;
        end
        drive(1'b1, 4'h0, 32'h0, 4'd0);
        chk("rr_wr_last", wr_en, 1);
        chk("rr_buf_last", buf_in, exp_prev);

        // Credit boundary and stall
        drive(1'b0, 4'h0, 32'h0, 4'd0);
        drive(1'b1, 4'b0001, 32'h0000_00A0, 4'd0);
        chk("full_ack0", ack, 4'b0001);
        drive(1'b1, 4'b0001, 32'h0000_00A1, 4'd7);
        chk("full_wr_inflight", wr_en, 1);
        chk("full_block_ack", ack, 0);
        drive(1'b1, 4'b0001, 32'h0000_00A1, 4'd8);
        chk("full_stall_ack", ack, 0);
        chk("full_stall_wr", wr_en, 0);
        chk("full_stall_grant", grant, 4'b0001);
        chk("full_stall_busy", busy, 1);
        drive(1'b1, 4'b0001, 32'h0000_00A1, 4'd6);
        chk("full_resume_ack", ack, 4'b0001);
        drive(1'b1, 4'b0000, 32'h0, 4'd0);
        chk("full_resume_wr", wr_en, 1);
        chk("full_resume_buf", buf_in, 8'hA1);

        // Early release by producer 2, pointer moves past it
        drive(1'b0, 4'h0, 32'h0, 4'd0);
        drive(1'b1, 4'b0100, 32'h00C0_0000, 4'd0);
        chk("rel_ack_p2a", ack, 4'b0100);
        drive(1'b1, 4'b1100, 32'hD0C1_0000, 4'd0);
        chk("rel_ack_p2b", ack, 4'b0100);
        drive(1'b1, 4'b1001, 32'hD000_00E0, 4'd0);
        chk("rel_ack_p3", ack, 4'b1000);
        chk("rel_buf_c1", buf_in, 8'hC1);
        drive(1'b1, 4'b0101, 32'h00C2_00E0, 4'd0);
        chk("rel_ack_p0", ack, 4'b0001);
        chk("rel_buf_d0", buf_in, 8'hD0);
        chk("rel_grant_p3", grant, 4'b1000);

        // Reset in the middle of a burst
        drive(1'b1, 4'b0000, 32'h0, 4'd0);
        drive(1'b1, 4'b0010, 32'h0000_5100, 4'd0);
        chk("mrst_ack_p1", ack, 4'b0010);
        drive(1'b0, 4'b0010, 32'h0000_5200, 4'd0);
        chk("mrst_ack_in_reset", ack, 0);
        chk("mrst_wr_before", wr_en, 1);
        drive(1'b1, 4'b0011, 32'h0000_5260, 4'd0);
        chk("mrst_wr_cleared", wr_en, 0);
        chk("mrst_grant_cleared", grant, 0);
        chk("mrst_busy_cleared", busy, 0);
        chk("mrst_restart_p0", ack, 4'b0001);
        drive(1'b1, 4'b0000, 32'h0, 4'd0);
        chk("mrst_buf_p0", buf_in, 8'h60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
